// File: rtl/priority_encoder.sv
// Edge-triggered 8-source interrupt priority encoder: rising edges latch into
// sticky pending bits, the lowest-index enabled pending source is granted until acked.
module priority_encoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ilines,
    input  logic       mask_wr,
    input  logic [7:0] mask_din,
    input  logic       ack,
    output logic [2:0] olines,
    output logic       int_req,
    output logic [7:0] pending
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_q, state_d;
    logic [7:0] prev_q, prev_d;
    logic [7:0] pending_q, pending_d;
    logic [7:0] mask_q, mask_d;
    logic [2:0] olines_q, olines_d;
    logic       int_req_q, int_req_d;

    logic [7:0] rise;
    logic [7:0] eligible;
    logic [2:0] win_idx;

    assign rise     = ilines & ~prev_q;
    assign eligible = pending_q & mask_q;

    // Descending scan so the lowest set index is the last one written.
    always_comb begin
        win_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (eligible[i]) win_idx = 3'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        prev_d    = ilines;
        pending_d = pending_q;
        mask_d    = mask_wr ? mask_din : mask_q;
        olines_d  = olines_q;
        int_req_d = int_req_q;
        case (state_q)
            IDLE: begin
                if (eligible != 8'h00) begin
                    olines_d  = win_idx;
                    int_req_d = 1'b1;
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                if (ack) begin
                    pending_d[olines_q] = 1'b0;
                    int_req_d           = 1'b0;
                    state_d             = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A new edge on the acked bit re-arms it in the same cycle.
        pending_d = pending_d | rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            prev_q    <= ilines;
            pending_q <= 8'h00;
            mask_q    <= 8'hFF;
            olines_q  <= 3'd0;
            int_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            olines_q  <= olines_d;
            int_req_q <= int_req_d;
        end
    end

    assign olines  = olines_q;
    assign int_req = int_req_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_priority_encoder.sv
// Scoreboard bench for priority_encoder: a behavioural model pushes expected
// outputs per driven cycle; they are popped and compared after the clock edge.
module tb_priority_encoder;

    logic       clk;
    logic       rst;
    logic [7:0] ilines;
    logic       mask_wr;
    logic [7:0] mask_din;
    logic       ack;
    logic [2:0] olines;
    logic       int_req;
    logic [7:0] pending;

    priority_encoder dut (
        .clk      (clk),
        .rst      (rst),
        .ilines   (ilines),
        .mask_wr  (mask_wr),
        .mask_din (mask_din),
        .ack      (ack),
        .olines   (olines),
        .int_req  (int_req),
        .pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] ol;
        logic       ir;
        logic [7:0] pend;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // model state
    logic [7:0] m_prev, m_pend, m_mask;
    logic [2:0] m_ol;
    logic       m_ir, m_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    task automatic model_step(input logic [7:0] il, input logic mw, input logic [7:0] md,
                              input logic a, input logic r);
        logic [7:0] rise, elig, n_pend;
        logic [2:0] n_ol;
        logic       n_ir, n_busy;
        if (r) begin
            m_prev = il; m_pend = 8'h00; m_mask = 8'hFF;
            m_ol = 3'd0; m_ir = 1'b0; m_busy = 1'b0;
        end else begin
            rise   = il & ~m_prev;
            n_pend = m_pend;
            n_ol   = m_ol;
            n_ir   = m_ir;
            n_busy = m_busy;
            if (!m_busy) begin
                elig = m_pend & m_mask;
                for (int i = 0; i < 8; i++) begin
                    if (elig[i] && !n_busy) begin
                        n_ol = 3'(i); n_ir = 1'b1; n_busy = 1'b1;
                    end
                end
            end else if (a) begin
                n_pend[m_ol] = 1'b0;
                n_ir = 1'b0; n_busy = 1'b0;
            end
            m_pend = n_pend | rise;
            m_ol = n_ol; m_ir = n_ir; m_busy = n_busy;
            if (mw) m_mask = md;
            m_prev = il;
        end
    endtask

    task automatic drive(input logic [7:0] il, input logic mw, input logic [7:0] md,
                         input logic a, input logic r);
        exp_t e;
        ilines = il; mask_wr = mw; mask_din = md; ack = a; rst = r;
        model_step(il, mw, md, a, r);
        exp_q.push_back('{ol: m_ol, ir: m_ir, pend: m_pend});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("olines", 32'(olines), 32'(e.ol));
        chk("int_req", 32'(int_req), 32'(e.ir));
        chk("pending", 32'(pending), 32'(e.pend));
    endtask

    task automatic line(input logic [7:0] il);
        drive(il, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic line_ack(input logic [7:0] il);
        drive(il, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        ilines = 8'h00; mask_wr = 1'b0; mask_din = 8'h00; ack = 1'b0; rst = 1'b1;
        @(negedge clk);
        drive(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("rst_ir", 32'(int_req), 32'h0);
        chk("rst_pend", 32'(pending), 32'h00);
        chk("rst_ol", 32'(olines), 32'h0);
        line_ack(8'h00);
        chk("idle_ack_ir", 32'(int_req), 32'h0);

        // single request on bit 3
        line(8'h08);
        chk("s_pend_k", 32'(pending), 32'h08);
        chk("s_ir_k", 32'(int_req), 32'h0);
        line(8'h08);
        chk("s_ir_k1", 32'(int_req), 32'h1);
        chk("s_ol_k1", 32'(olines), 32'h3);
        line(8'h08);
        line_ack(8'h08);
        chk("s_ir_ack", 32'(int_req), 32'h0);
        chk("s_pend_ack", 32'(pending), 32'h00);
        chk("s_ol_hold", 32'(olines), 32'h3);
        line(8'h00);

        // bits 5 and 2 together
        line(8'h24);
        line(8'h24);
        chk("p_ol_first", 32'(olines), 32'h2);
        line(8'h00);
        chk("p_hold_fall", 32'(olines), 32'h2);
        line_ack(8'h00);
        chk("p_idle_ir", 32'(int_req), 32'h0);
        chk("p_idle_pend", 32'(pending), 32'h20);
        line(8'h00);
        chk("p_ol_second", 32'(olines), 32'h5);
        chk("p_ir_second", 32'(int_req), 32'h1);
        line_ack(8'h00);

        // masking
        drive(8'h00, 1'b1, 8'hFE, 1'b0, 1'b0);
        line(8'h01);
        chk("m_pend", 32'(pending), 32'h01);
        line(8'h01);
        line(8'h01);
        chk("m_ir_masked", 32'(int_req), 32'h0);
        drive(8'h01, 1'b1, 8'hFF, 1'b0, 1'b0);
        chk("m_old_mask", 32'(int_req), 32'h0);
        line(8'h01);
        chk("m_ir_unmask", 32'(int_req), 32'h1);
        chk("m_ol_unmask", 32'(olines), 32'h0);
        line_ack(8'h00);

        // set-wins collision on bit 4, plus masking the granted source
        line(8'h10);
        line(8'h10);
        chk("c_ol", 32'(olines), 32'h4);
        drive(8'h00, 1'b1, 8'hEF, 1'b0, 1'b0);
        line(8'h01);
        chk("c_keep_grant", 32'(int_req), 32'h1);
        chk("c_keep_ol", 32'(olines), 32'h4);
        drive(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0);
        line_ack(8'h10);
        chk("c_ir_ack", 32'(int_req), 32'h0);
        chk("c_pend4", 32'(pending[4]), 32'h1);
        line(8'h10);
        chk("c_regrant", 32'(olines), 32'h0);
        line_ack(8'h00);
        line(8'h00);
        chk("c_regrant4", 32'(olines), 32'h4);
        line_ack(8'h00);
        line(8'h00);

        // reset mid-grant with all lines held high
        line(8'hFF);
        line(8'hFF);
        chk("r_grant", 32'(int_req), 32'h1);
        drive(8'hFF, 1'b1, 8'h00, 1'b1, 1'b1);
        chk("r_pend", 32'(pending), 32'h00);
        chk("r_ir", 32'(int_req), 32'h0);
        line(8'hFF);
        line(8'hFF);
        line(8'hFF);
        chk("r_no_grant", 32'(int_req), 32'h0);
        chk("r_no_pend", 32'(pending), 32'h00);
        line(8'h7F);
        line(8'hFF);
        line(8'hFF);
        chk("r_mask_ff", 32'(int_req), 32'h1);
        chk("r_ol7", 32'(olines), 32'h7);

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            drive(8'($urandom), ($urandom_range(0, 7) == 0), 8'($urandom),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 40) == 0));
        end

        if (exp_q.size() != 0) chk("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
